// File: rtl/cla_serial_add_ctrl.sv
// cla_serial_add_ctrl
//   Adds two WIDTH-bit operands one nibble per clock through a single 4-bit
//   carry-look-ahead adder. The carry between nibbles is kept in a register,
//   and the sum is assembled in place. Inputs and outputs use valid/ready
//   handshakes. A new operation is accepted only after the previous result
//   has been taken.
//
//   Optional feature: define CLA_SERIAL_OVF_EN to add the 'ovf' output. It
//   flags two's-complement signed overflow of the final sum.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous, active-low reset
//   in_valid   a, b and cin are valid
//   in_ready   block can accept a new operation (registered)
//   a, b       WIDTH-bit operands
//   cin        carry-in
//   out_valid  sum and cout are valid
//   out_ready  consumer accepts the result
//   sum        a + b + cin modulo 2^WIDTH
//   cout       carry out of bit WIDTH-1
//   busy       operation in flight (RUN or DONE)
//   ovf        signed overflow (only with CLA_SERIAL_OVF_EN)

module carry_look_ahead_adder_behavioral (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);
    logic [3:0] g, p;
    logic [4:0] c;

    assign g = A & B;
    assign p = A ^ B;

    always_comb begin
        c    = '0;
        c[0] = Cin;
        for (int i = 0; i < 4; i++)
            c[i+1] = g[i] | (p[i] & c[i]);
    end

    assign S    = p ^ c[3:0];
    assign Cout = c[4];
endmodule

module cla_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef CLA_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NIBBLES - 1);

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
            $error("cla_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [WIDTH-1:0]  a_reg, b_reg;
    logic              carry;
    logic [IDXW-1:0]   idx;

    logic [3:0] cla_a, cla_b, cla_s;
    logic       cla_co;

    // The adder always sees the nibble selected by idx. Its output is only
    // stored while in RUN.
    assign cla_a = a_reg[4*idx +: 4];
    assign cla_b = b_reg[4*idx +: 4];

    carry_look_ahead_adder_behavioral u_cla (
        .A    (cla_a),
        .B    (cla_b),
        .Cin  (carry),
        .S    (cla_s),
        .Cout (cla_co)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            idx       <= '0;
            carry     <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
`ifdef CLA_SERIAL_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // in_ready comes up one edge after reset or after a result
                    // handshake. Acceptance uses the registered value.
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        a_reg    <= a;
                        b_reg    <= b;
                        carry    <= cin;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum[4*idx +: 4] <= cla_s;
                    carry           <= cla_co;
                    idx             <= idx + IDXW'(1);
                    if (idx == LAST) begin
                        idx       <= '0;
                        cout      <= cla_co;
                        out_valid <= 1'b1;
                        state     <= DONE;
`ifdef CLA_SERIAL_OVF_EN
                        // cla_s[3] is the final sum MSB being written on this edge.
                        ovf <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                               (cla_s[3] != a_reg[WIDTH-1]);
`endif
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
module tb_cla_serial_add_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [15:0] a, b;
    logic        cin;
    logic        out_valid, out_ready;
    logic [15:0] sum;
    logic        cout, busy;
`ifdef CLA_SERIAL_OVF_EN
    logic        ovf;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    cla_serial_add_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef CLA_SERIAL_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Present operands, take the accepting edge, then check exact 4-cycle latency.
    task automatic run_op(input logic [15:0] va, input logic [15:0] vb, input logic vc);
        in_valid = 1'b1; a = va; b = vb; cin = vc;
        step();
        in_valid = 1'b0;
        chk("acc_in_ready_low", in_ready, 0);
        chk("acc_busy", busy, 1);
        for (int k = 1; k < 4; k++) begin
            step();
            chk("lat_out_valid_low", out_valid, 0);
        end
        step();
        chk("lat_out_valid_high", out_valid, 1);
        chk("done_in_ready_low", in_ready, 0);
    endtask

    task automatic check_res(input logic [15:0] es, input logic ec, input logic eo);
        chk("sum", sum, es);
        chk("cout", cout, ec);
`ifdef CLA_SERIAL_OVF_EN
        chk("ovf", ovf, eo);
`else
        if (eo === 1'bx) $display("unused");
`endif
    endtask

    task automatic retire();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("ret_out_valid", out_valid, 0);
        chk("ret_in_ready", in_ready, 1);
        chk("ret_busy", busy, 0);
    endtask

    logic [15:0] qa [3];
    logic [15:0] qb [3];
    logic        qc [3];
    logic [15:0] qs [3];
    logic        qco[3];
    int          acc_cyc[3];

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        step(); step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        rst_n = 1'b1;
        chk("rel_in_ready_still_low", in_ready, 0);
        step();
        chk("rel_in_ready_up", in_ready, 1);

        // Basic add
        run_op(16'h1234, 16'h4321, 1'b0);
        check_res(16'h5555, 1'b0, 1'b0);
        retire();

        // Full ripple
        run_op(16'hFFFF, 16'h0001, 1'b0);
        check_res(16'h0000, 1'b1, 1'b0);
        retire();
        run_op(16'hFFFF, 16'hFFFF, 1'b1);
        check_res(16'hFFFF, 1'b1, 1'b0);
        retire();

        // Backpressure with a pending new input
        run_op(16'h1111, 16'h2222, 1'b0);
        check_res(16'h3333, 1'b0, 1'b0);
        in_valid = 1'b1; a = 16'h000A; b = 16'h0005; cin = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_out_valid", out_valid, 1);
            chk("bp_sum", sum, 16'h3333);
            chk("bp_cout", cout, 0);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_idle_busy", busy, 0);
        chk("bp_idle_out_valid", out_valid, 0);
        chk("bp_idle_in_ready", in_ready, 1);
        run_op(16'h000A, 16'h0005, 1'b0);
        check_res(16'h000F, 1'b0, 1'b0);
        retire();

        // Reset after two RUN cycles
        in_valid = 1'b1; a = 16'h1234; b = 16'h1111; cin = 1'b0;
        step();
        in_valid = 1'b0;
        step(); step();
        chk("mid_partial_sum", sum, 16'h0045);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_sum", sum, 0);
        step();
        rst_n = 1'b1;
        chk("mid_rel_in_ready_low", in_ready, 0);
        step();
        chk("mid_rel_in_ready_up", in_ready, 1);
        run_op(16'h8000, 16'h8000, 1'b0);
        check_res(16'h0000, 1'b1, 1'b1);
        retire();

        // Back-to-back with in_valid and out_ready held high
        qa[0] = 16'h0001; qb[0] = 16'h0002; qc[0] = 1'b0; qs[0] = 16'h0003; qco[0] = 1'b0;
        qa[1] = 16'h00FF; qb[1] = 16'h0001; qc[1] = 1'b1; qs[1] = 16'h0101; qco[1] = 1'b0;
        qa[2] = 16'hF000; qb[2] = 16'h1000; qc[2] = 1'b0; qs[2] = 16'h0000; qco[2] = 1'b1;
        begin
            int ni = 0;
            int no = 0;
            logic acc;
            in_valid = 1'b1; a = qa[0]; b = qb[0]; cin = qc[0];
            out_ready = 1'b1;
            for (int c = 0; c < 60 && no < 3; c++) begin
                acc = in_valid && in_ready;
                step();
                if (acc) begin
                    acc_cyc[ni] = cyc;
                    ni++;
                    if (ni < 3) begin
                        a = qa[ni]; b = qb[ni]; cin = qc[ni];
                    end else begin
                        in_valid = 1'b0;
                    end
                end
                if (out_valid) begin
                    chk("b2b_sum", sum, qs[no]);
                    chk("b2b_cout", cout, qco[no]);
                    chk("b2b_latency", cyc - acc_cyc[no], 4);
                    no++;
                end
            end
            chk("b2b_count", no, 3);
            out_ready = 1'b0;
            in_valid  = 1'b0;
            step();
        end

`ifdef CLA_SERIAL_OVF_EN
        run_op(16'h7FFF, 16'h0001, 1'b0);
        check_res(16'h8000, 1'b0, 1'b1);
        retire();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
